// File: rtl/text_console.sv
// Character-stream front end: turns ASCII bytes into cell writes, screen clears and
// one-row scrolls on the video card's STB/WE/ADDR/DAT/ACK port, tracking an 80x30 cursor.
module text_console #(
  parameter logic [7:0] ATTR = 8'h00,
  parameter int         COLS = 80,
  parameter int         ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADDR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam logic [11:0] ROW_CELLS = 12'(COLS);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROW  = 12'(COLS * ROWS - COLS);
  localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
  localparam logic [4:0]  Y_MAX     = 5'(ROWS - 1);
  localparam logic [15:0] BLANK     = {ATTR, 8'h20};

  typedef enum logic [2:0] {
    S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_SCR_CLR, S_CLR
  } state_t;

  // PH_START waits for ACK low before the first strobe of an operation, so a
  // stale ACK left over from an abandoned cycle is never taken as an answer.
  typedef enum logic [1:0] {
    PH_START, PH_STB, PH_GAP
  } phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [11:0] idx_q, idx_d;
  logic [15:0] rd_q, rd_d;
  logic [6:0]  cx_q, cx_d, nx_q, nx_d;
  logic [4:0]  cy_q, cy_d, ny_q, ny_d;
  logic        scr_pend_q, scr_pend_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] dat_q, dat_d;
  logic        ready_q, ready_d;

  logic        launch;
  logic        finish;
  logic [11:0] pos;

  logic unused_dat_hi;
  assign unused_dat_hi = ^DAT_I[31:16];

  function automatic logic [11:0] cell_addr(input logic [4:0] y, input logic [6:0] x);
    return ({7'd0, y} * ROW_CELLS) + {5'd0, x};
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    scr_pend_d = scr_pend_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    launch     = 1'b0;
    finish     = 1'b0;
    pos        = cell_addr(cy_q, cx_q);

    if (state_q == S_IDLE) begin
      if (char_valid) begin
        if (char_in >= 8'h20 && char_in <= 8'h7E) begin
          state_d    = S_PUT;
          phase_d    = PH_START;
          we_d       = 1'b1;
          addr_d     = pos;
          dat_d      = {ATTR, char_in};
          scr_pend_d = 1'b0;
          ny_d       = cy_q;
          if (cx_q == X_MAX) begin
            nx_d = 7'd0;
            if (cy_q == Y_MAX) scr_pend_d = 1'b1;
            else               ny_d = cy_q + 5'd1;
          end else begin
            nx_d = cx_q + 7'd1;
          end
        end else begin
          case (char_in)
            8'h0A: begin
              if (cy_q == Y_MAX) begin
                state_d = S_SCR_RD;
                phase_d = PH_START;
                idx_d   = ROW_CELLS;
                nx_d    = 7'd0;
                ny_d    = Y_MAX;
              end else begin
                cx_d = 7'd0;
                cy_d = cy_q + 5'd1;
              end
            end
            8'h0D: cx_d = 7'd0;
            8'h08: begin
              if (cx_q != 7'd0) begin
                state_d    = S_PUT;
                phase_d    = PH_START;
                we_d       = 1'b1;
                addr_d     = pos - 12'd1;
                dat_d      = BLANK;
                nx_d       = cx_q - 7'd1;
                ny_d       = cy_q;
                scr_pend_d = 1'b0;
              end
            end
            8'h0C: begin
              state_d = S_CLR;
              phase_d = PH_START;
              idx_d   = 12'd0;
              nx_d    = 7'd0;
              ny_d    = 5'd0;
            end
            default: ;
          endcase
        end
      end
    end else begin
      case (phase_q)
        PH_START: if (!ACK) launch = 1'b1;
        PH_STB: begin
          if (ACK) begin
            stb_d   = 1'b0;
            phase_d = PH_GAP;
            if (!we_q) rd_d = DAT_I[15:0];
          end
        end
        PH_GAP: begin
          if (!ACK) begin
            case (state_q)
              S_PUT: begin
                if (scr_pend_q) begin
                  state_d = S_SCR_RD;
                  idx_d   = ROW_CELLS;
                  launch  = 1'b1;
                end else begin
                  finish = 1'b1;
                end
              end
              S_SCR_RD: begin
                state_d = S_SCR_WR;
                launch  = 1'b1;
              end
              S_SCR_WR: begin
                if (idx_q == LAST_CELL) begin
                  state_d = S_SCR_CLR;
                  idx_d   = LAST_ROW;
                end else begin
                  state_d = S_SCR_RD;
                  idx_d   = idx_q + 12'd1;
                end
                launch = 1'b1;
              end
              S_SCR_CLR, S_CLR: begin
                if (idx_q == LAST_CELL) begin
                  finish = 1'b1;
                end else begin
                  idx_d  = idx_q + 12'd1;
                  launch = 1'b1;
                end
              end
              default: finish = 1'b1;
            endcase
          end
        end
        default: phase_d = PH_START;
      endcase
    end

    // Bus fields are registered together with the strobe so they stay stable for the cycle.
    if (launch) begin
      stb_d   = 1'b1;
      phase_d = PH_STB;
      case (state_d)
        S_PUT:    we_d = 1'b1;
        S_SCR_RD: begin
          we_d   = 1'b0;
          addr_d = idx_d;
        end
        S_SCR_WR: begin
          we_d   = 1'b1;
          addr_d = idx_d - ROW_CELLS;
          dat_d  = rd_d;
        end
        default: begin
          we_d   = 1'b1;
          addr_d = idx_d;
          dat_d  = BLANK;
        end
      endcase
    end

    if (finish) begin
      state_d = S_IDLE;
      phase_d = PH_START;
      cx_d    = nx_q;
      cy_d    = ny_q;
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_START;
      idx_q      <= 12'd0;
      rd_q       <= 16'd0;
      cx_q       <= 7'd0;
      cy_q       <= 5'd0;
      nx_q       <= 7'd0;
      ny_q       <= 5'd0;
      scr_pend_q <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 12'd0;
      dat_q      <= 16'd0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      scr_pend_q <= scr_pend_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      ready_q    <= ready_d;
    end
  end

  assign char_ready = ready_q;
  assign STB        = stb_q;
  assign WE         = we_q;
  assign ADDR       = {20'd0, addr_q};
  assign DAT_O      = {16'd0, dat_q};
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: a video-card model with adjustable ACK timing, plus a
// screen/cursor reference model that predicts every bus transaction per byte.
module tb_text_console;

  localparam logic [7:0]  ATTR  = 8'h00;
  localparam logic [15:0] BLANK = {ATTR, 8'h20};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I = 32'd0;
  logic        ACK = 1'b0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  always #5 clk = ~clk;

  text_console dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK(ACK), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } tx_t;

  int total = 0;
  int bad   = 0;

  // ---------------- video card model ----------------
  int          ack_dly  = 1;
  int          ack_hold = 1;
  int          stb_cnt  = 0;
  int          hold_cnt = 0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem [0:4095];
  tx_t         log_q[$];
  int          proto_bad = 0;
  logic        stb_prev = 1'b0;
  logic [64:0] bus_prev = '0;
  int          cyc = 0;

  function automatic logic [15:0] init_cell(input int i);
    return 16'((i * 40503 + 12345) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_cell(i);
      mem_ready <= 1'b1;
    end else begin
      if (STB && !stb_prev && ACK) proto_bad <= proto_bad + 1;
      if (STB && stb_prev && ({WE, ADDR, DAT_O} != bus_prev)) proto_bad <= proto_bad + 1;
      stb_prev <= STB;
      bus_prev <= {WE, ADDR, DAT_O};
      if (ACK) begin
        stb_cnt <= 0;
        if (hold_cnt + 1 >= ack_hold) begin
          ACK      <= 1'b0;
          hold_cnt <= 0;
        end else begin
          hold_cnt <= hold_cnt + 1;
        end
      end else if (STB) begin
        if (stb_cnt + 1 >= ack_dly) begin
          ACK     <= 1'b1;
          stb_cnt <= 0;
          if (WE) begin
            mem[ADDR[11:0]] <= DAT_O[15:0];
            log_q.push_back({1'b1, ADDR, DAT_O});
          end else begin
            DAT_I <= {16'hA5A5, mem[ADDR[11:0]]};
            log_q.push_back({1'b0, ADDR, 16'h0000, mem[ADDR[11:0]]});
          end
        end else begin
          stb_cnt <= stb_cnt + 1;
        end
      end else begin
        stb_cnt <= 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] scr [0:2399];
  int          mx = 0;
  int          my = 0;
  tx_t         exp_q[$];

  function automatic void m_write(input int a, input logic [15:0] v);
    exp_q.push_back({1'b1, 32'(a), 16'h0000, v});
    scr[a] = v;
  endfunction

  function automatic void m_next_row();
    if (my < 29) begin
      my = my + 1;
    end else begin
      for (int i = 80; i < 2400; i++) begin
        exp_q.push_back({1'b0, 32'(i), 16'h0000, scr[i]});
        m_write(i - 80, scr[i]);
      end
      for (int i = 2320; i < 2400; i++) m_write(i, BLANK);
    end
  endfunction

  function automatic void m_byte(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_write(my * 80 + mx, {ATTR, c});
      mx = mx + 1;
      if (mx == 80) begin
        mx = 0;
        m_next_row();
      end
    end else if (c == 8'h0A) begin
      mx = 0;
      m_next_row();
    end else if (c == 8'h0D) begin
      mx = 0;
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx = mx - 1;
        m_write(my * 80 + mx, BLANK);
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < 2400; i++) m_write(i, BLANK);
      mx = 0;
      my = 0;
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) return i;
    if (log_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    char_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    mx = 0;
    my = 0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic accept_byte(input logic [7:0] c);
    int n;
    @(negedge clk);
    char_in    = c;
    char_valid = 1'b1;
    n = 0;
    while (!char_ready && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: char_ready=%0b after %0d cycles, required 1", char_ready, n);
    end
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    @(negedge clk);
    while (!char_ready && low < 40000) begin
      low++;
      @(negedge clk);
    end
    if (!char_ready) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: char_ready still 0 after %0d cycles", low);
    end
  endtask

  task automatic send_byte(input logic [7:0] c, output int low);
    accept_byte(c);
    wait_ready(low);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (STB !== 1'b0) begin bad++; $display("FAIL rst_stb: got %b want 0", STB); end
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", WE); end
    total++; if (ADDR !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", ADDR); end
    total++; if (DAT_O !== 32'd0) begin bad++; $display("FAIL rst_dat: got %h want 0", DAT_O); end
    total++; if ({cursor_x, cursor_y} !== 12'd0) begin bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
    total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", char_ready); end
  endtask

  task automatic test_put();
    int low;
    tx_t e;
    send_byte(8'h41, low);
    m_byte(8'h41);
    e = {1'b1, 32'd0, 32'h0000_0041};
    total++; if (low !== 4) begin bad++; $display("FAIL put_latency: got %0d want 4", low); end
    total++; if (log_q.size() !== 1) begin bad++; $display("FAIL put_count: got %0d want 1", log_q.size()); end
    else begin
      total++; if (log_q[0] !== e) begin bad++; $display("FAIL put_tx: got %h want %h", log_q[0], e); end
    end
    total++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin bad++; $display("FAIL put_cursor: got (%0d,%0d) want (1,0)", cursor_x, cursor_y); end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_newline();
    int low;
    tx_t e;
    apply_reset();
    send_byte(8'h0A, low);
    m_byte(8'h0A);
    total++; if (log_q.size() !== 0) begin bad++; $display("FAIL nl_traffic: got %0d tx want 0", log_q.size()); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin bad++; $display("FAIL nl_cursor: got (%0d,%0d) want (0,1)", cursor_x, cursor_y); end
    send_byte(8'h42, low);
    m_byte(8'h42);
    e = {1'b1, 32'd80, 32'h0000_0042};
    total++; if (log_q.size() !== 1 || log_q[0] !== e) begin bad++; $display("FAIL nl_put_tx: got n=%0d first=%h want %h", log_q.size(), (log_q.size() > 0) ? log_q[0] : '0, e); end
    total++; if (cursor_x !== 7'd1 || cursor_y !== 5'd1) begin bad++; $display("FAIL nl_put_cursor: got (%0d,%0d) want (1,1)", cursor_x, cursor_y); end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    int low;
    int nbad;
    tx_t e;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      send_byte(8'h30, low);
      m_byte(8'h30);
    end
    nbad = 0;
    for (int i = 0; i < 80; i++) begin
      e = {1'b1, 32'(i), 32'h0000_0030};
      if (i >= log_q.size() || log_q[i] !== e) nbad++;
    end
    total++; if (nbad !== 0 || log_q.size() !== 80) begin bad++; $display("FAIL wrap_tx: %0d wrong of %0d tx, want 80 writes to 0..79", nbad, log_q.size()); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", cursor_x, cursor_y); end
    log_q.delete(); exp_q.delete();
    send_byte(8'h08, low);
    m_byte(8'h08);
    total++; if (log_q.size() !== 0 || low !== 0) begin bad++; $display("FAIL bs_x0: got %0d tx busy %0d want none", log_q.size(), low); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin bad++; $display("FAIL bs_x0_cursor: got (%0d,%0d) want (0,1)", cursor_x, cursor_y); end
    send_byte(8'h41, low);
    m_byte(8'h41);
    log_q.delete(); exp_q.delete();
    send_byte(8'h08, low);
    m_byte(8'h08);
    e = {1'b1, 32'd80, 16'h0000, BLANK};
    total++; if (log_q.size() !== 1 || log_q[0] !== e) begin bad++; $display("FAIL bs_tx: got n=%0d first=%h want %h", log_q.size(), (log_q.size() > 0) ? log_q[0] : '0, e); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin bad++; $display("FAIL bs_cursor: got (%0d,%0d) want (0,1)", cursor_x, cursor_y); end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_scroll();
    int low;
    int d;
    int nbad;
    int n;
    logic [15:0] c80;
    tx_t e;
    ack_dly = 1; ack_hold = 1;
    apply_reset();
    for (int i = 0; i < 29; i++) begin send_byte(8'h0A, low); m_byte(8'h0A); end
    for (int i = 0; i < 5; i++) begin send_byte(8'(8'h61 + i), low); m_byte(8'(8'h61 + i)); end
    total++; if (cursor_x !== 7'd5 || cursor_y !== 5'd29) begin bad++; $display("FAIL pre_scroll_cursor: got (%0d,%0d) want (5,29)", cursor_x, cursor_y); end
    log_q.delete(); exp_q.delete();
    c80 = scr[80];
    send_byte(8'h0A, low);
    m_byte(8'h0A);
    n = log_q.size();
    total++; if (n !== 4720) begin bad++; $display("FAIL scroll_count: got %0d tx want 4720", n); end
    e = {1'b0, 32'd80, 16'h0000, c80};
    total++; if (n < 2 || log_q[0] !== e) begin bad++; $display("FAIL scroll_first_rd: got %h want %h", (n > 0) ? log_q[0] : '0, e); end
    e = {1'b1, 32'd0, 16'h0000, c80};
    total++; if (n < 2 || log_q[1] !== e) begin bad++; $display("FAIL scroll_first_wr: got %h want %h", (n > 1) ? log_q[1] : '0, e); end
    nbad = 0;
    for (int i = 0; i < 80; i++) begin
      e = {1'b1, 32'(2320 + i), 32'h0000_0020};
      if (n < 80 || log_q[n - 80 + i] !== e) nbad++;
    end
    total++; if (nbad !== 0) begin bad++; $display("FAIL scroll_blank_row: %0d of 80 final writes wrong", nbad); end
    d = first_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL scroll_model: first differing tx %0d (got %0d tx, model %0d)", d, n, exp_q.size()); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin bad++; $display("FAIL scroll_cursor: got (%0d,%0d) want (0,29)", cursor_x, cursor_y); end
    total++; if (low < 14160 || low > 14161) begin bad++; $display("FAIL scroll_busy: char_ready low %0d clocks, want 14160 (+1 launch)", low); end
    total++; if (proto_bad !== 0) begin bad++; $display("FAIL scroll_protocol: %0d bus rule breaks, want 0", proto_bad); end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear();
    int low;
    int nbad;
    tx_t e;
    send_byte(8'h0C, low);
    m_byte(8'h0C);
    nbad = 0;
    for (int i = 0; i < 2400; i++) begin
      e = {1'b1, 32'(i), 32'h0000_0020};
      if (i >= log_q.size() || log_q[i] !== e) nbad++;
    end
    total++; if (nbad !== 0 || log_q.size() !== 2400) begin bad++; $display("FAIL clear_tx: %0d wrong, %0d tx, want 2400 ascending blanks", nbad, log_q.size()); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++; $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
    log_q.delete(); exp_q.delete();
    send_byte(8'h07, low);
    m_byte(8'h07);
    total++; if (log_q.size() !== 0 || low !== 0) begin bad++; $display("FAIL bel_ignored: got %0d tx busy %0d want none", log_q.size(), low); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++; $display("FAIL bel_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
  endtask

  task automatic test_random();
    int low;
    int r;
    int d;
    int nbad;
    logic [7:0] c;
    for (int k = 0; k < 200; k++) begin
      ack_dly  = $urandom_range(3, 1);
      ack_hold = $urandom_range(2, 1);
      r = $urandom_range(99);
      if (r < 70)      c = 8'($urandom_range(8'h7E, 8'h20));
      else if (r < 78) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 93) c = 8'h08;
      else begin
        c = 8'($urandom_range(255));
        if (c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C || (c >= 8'h20 && c <= 8'h7E)) c = 8'h7F;
      end
      send_byte(c, low);
      m_byte(c);
      d = first_diff();
      total++; if (d !== -1) begin bad++; $display("FAIL rand_tx[%0d] byte %h: first diff at %0d (got %0d tx, model %0d)", k, c, d, log_q.size(), exp_q.size()); end
      total++; if (cursor_x !== 7'(mx) || cursor_y !== 5'(my)) begin bad++; $display("FAIL rand_cursor[%0d] byte %h: got (%0d,%0d) want (%0d,%0d)", k, c, cursor_x, cursor_y, mx, my); end
      log_q.delete(); exp_q.delete();
    end
    nbad = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== scr[i]) nbad++;
    total++; if (nbad !== 0) begin bad++; $display("FAIL rand_screen: %0d cells differ from model", nbad); end
    total++; if (proto_bad !== 0) begin bad++; $display("FAIL rand_protocol: %0d bus rule breaks, want 0", proto_bad); end
    ack_dly = 1; ack_hold = 1;
  endtask

  task automatic test_reset_mid();
    int low;
    int n;
    int pb;
    tx_t e;
    ack_dly = 1; ack_hold = 4;
    apply_reset();
    for (int i = 0; i < 29; i++) begin send_byte(8'h0A, low); m_byte(8'h0A); end
    accept_byte(8'h0A);
    n = 0;
    @(negedge clk);
    while (n < 60 || !(STB && ACK)) begin
      @(negedge clk);
      n++;
      if (n > 500) break;
    end
    total++; if (!(STB && ACK)) begin bad++; $display("FAIL midrst_busy: STB=%b ACK=%b, scroll never reached a strobe", STB, ACK); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (STB !== 1'b0) begin bad++; $display("FAIL midrst_stb: got %b want 0", STB); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++; $display("FAIL midrst_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
    total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", char_ready); end
    pb = proto_bad;
    log_q.delete();
    send_byte(8'h41, low);
    e = {1'b1, 32'd0, 32'h0000_0041};
    total++; if (log_q.size() !== 1 || log_q[0] !== e) begin bad++; $display("FAIL midrst_put: got n=%0d first=%h want %h", log_q.size(), (log_q.size() > 0) ? log_q[0] : '0, e); end
    total++; if (proto_bad !== pb) begin bad++; $display("FAIL midrst_stale_ack: %0d strobes overlapped ACK, want 0", proto_bad - pb); end
    total++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin bad++; $display("FAIL midrst_cursor2: got (%0d,%0d) want (1,0)", cursor_x, cursor_y); end
    ack_hold = 1;
  endtask

  initial begin
    for (int i = 0; i < 2400; i++) scr[i] = init_cell(i);
    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    test_reset();
    test_put();
    test_newline();
    test_wrap();
    test_scroll();
    test_clear();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 200000 clocks (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
